// File: rtl/alu_nseq.sv
// alu_nseq: nibble-serial ALU, one nibble per RDY-qualified clock, start/busy/done handshake.
// Define ALU_NSEQ_BCD_EN to build per-digit decimal correction for ADD/SUB; otherwise BCD is ignored.
module alu_nseq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             RDY,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             CI,
  input  logic             BCD,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] OUT,
  output logic             CO,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic             HC
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_c;
  logic             r_hc;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_res [DIGITS];

  logic [WIDTH-1:0] r_out;
  logic             r_co;
  logic             r_v;
  logic             r_z;
  logic             r_n;
  logic             r_hc_out;

  logic [CW-1:0]    w_idx;
  logic [3:0]       w_a_arr [DIGITS];
  logic [3:0]       w_b_arr [DIGITS];
  logic [WIDTH-1:0] w_res_flat;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_bp;
  logic [4:0]       w_sum;
  logic [3:0]       w_digit;
  logic             w_carry;
  logic             w_v_calc;

`ifdef ALU_NSEQ_BCD_EN
  logic             r_bcd;
  logic [4:0]       w_adj;
`else
  logic             w_unused_bcd;
  assign w_unused_bcd = BCD;
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
    end else if (RDY) begin
      r_state <= w_state_next;
    end
  end

  assign w_last = (r_cnt == CW'(DIGITS - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && RDY) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start && RDY) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- nibble datapath ----------------
  // SHR walks from the top nibble down so CI can enter bit WIDTH-1 first.
  assign w_idx = (r_op == OP_SHR) ? (CW'(DIGITS - 1) - r_cnt) : r_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_a_arr[gi]             = r_a[gi*4 +: 4];
      assign w_b_arr[gi]             = r_b[gi*4 +: 4];
      assign w_res_flat[gi*4 +: 4]   = (w_idx == CW'(gi)) ? w_digit : r_res[gi];
    end
  endgenerate

  assign w_a_nib = w_a_arr[w_idx];
  assign w_b_nib = w_b_arr[w_idx];
  assign w_bp    = (r_op == OP_SUB) ? ~w_b_nib : w_b_nib;
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_bp} + {4'b0000, r_c};

  // Overflow uses the uncorrected sum; only meaningful on the top nibble, which ADD/SUB reach last.
  assign w_v_calc = ((r_op == OP_ADD) || (r_op == OP_SUB)) &&
                    (w_a_nib[3] == w_bp[3]) && (w_sum[3] != w_a_nib[3]);

  always_comb begin
    w_digit = w_a_nib;
    w_carry = r_c;
`ifdef ALU_NSEQ_BCD_EN
    w_adj   = '0;
`endif
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_digit = w_sum[3:0];
        w_carry = w_sum[4];
`ifdef ALU_NSEQ_BCD_EN
        if (r_bcd) begin
          if (r_op == OP_ADD) begin
            if (w_sum > 5'd9) begin
              w_adj   = w_sum + 5'd6;
              w_digit = w_adj[3:0];
              w_carry = 1'b1;
            end
          end else if (!w_sum[4]) begin
            w_digit = w_sum[3:0] + 4'd10;
          end
        end
`endif
      end
      OP_SHL: begin
        w_digit = {w_a_nib[2:0], r_c};
        w_carry = w_a_nib[3];
      end
      OP_SHR: begin
        w_digit = {r_c, w_a_nib[3:1]};
        w_carry = w_a_nib[0];
      end
      OP_OR:   w_digit = w_a_nib | w_b_nib;
      OP_AND:  w_digit = w_a_nib & w_b_nib;
      OP_XOR:  w_digit = w_a_nib ^ w_b_nib;
      OP_PASS: w_digit = w_a_nib;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_c      <= 1'b0;
      r_hc     <= 1'b0;
      r_cnt    <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        r_res[i] <= '0;
      end
      r_out    <= '0;
      r_co     <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_hc_out <= 1'b0;
`ifdef ALU_NSEQ_BCD_EN
      r_bcd    <= 1'b0;
`endif
    end else if (RDY) begin
      if (w_accept) begin
        r_a   <= AI;
        r_b   <= BI;
        r_op  <= op;
        r_c   <= CI;
        r_cnt <= '0;
`ifdef ALU_NSEQ_BCD_EN
        r_bcd <= BCD;
`endif
      end else if (r_state == ST_RUN) begin
        r_res[w_idx] <= w_digit;
        r_c          <= w_carry;
        r_cnt        <= r_cnt + CW'(1);
        if (w_idx == '0) begin
          r_hc <= w_carry;
        end
        if (w_last) begin
          r_out    <= w_res_flat;
          r_co     <= w_carry;
          r_v      <= w_v_calc;
          r_z      <= (w_res_flat == '0);
          r_n      <= w_res_flat[WIDTH-1];
          r_hc_out <= (w_idx == '0) ? w_carry : r_hc;
        end
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign OUT  = r_out;
  assign CO   = r_co;
  assign V    = r_v;
  assign Z    = r_z;
  assign N    = r_n;
  assign HC   = r_hc_out;

endmodule
